multi_colour_bbox: RTL and testbench

- Multi-colour bounding-box tracker that follows the per-pixel colour classifier in the vision pipeline.
- Counts pixel coordinates and tracks min/max x/y per colour class inside a programmable region of interest (ROI).
- At end of frame, snapshots the boxes and, every INTERVAL frames, writes a multi-word message into an internal FIFO.
- The NIOS reads the FIFO through an Avalon-MM slave.

---
 rtl/multi_colour_bbox.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_multi_colour_bbox.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_colour_bbox.sv
// Multi-colour bounding-box tracker with a show-ahead message FIFO read over Avalon-MM.
// Define BBOX_COUNT_EN to append a per-colour matched-pixel COUNT word to every message.
module multi_colour_bbox #(
    parameter int unsigned NUM_COLOURS  = 4,
    parameter int unsigned COORD_W      = 11,
    parameter int unsigned IMAGE_W      = 640,
    parameter int unsigned IMAGE_H      = 480,
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned MSG_INTERVAL = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_valid,
    input  logic                   pix_sop,
    input  logic                   pix_eop,
    input  logic                   pix_video,
    input  logic [NUM_COLOURS-1:0] pix_match,
    input  logic                   s_chipselect,
    input  logic                   s_read,
    input  logic                   s_write,
    input  logic [2:0]             s_address,
    input  logic [31:0]            s_writedata,
    output logic [31:0]            s_readdata,
    output logic                   msg_avail
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
`ifdef BBOX_COUNT_EN
    localparam int unsigned WORDS_PER_COLOUR = 3;
    localparam logic [7:0]  HDR_FLAG         = 8'h80;
`else
    localparam int unsigned WORDS_PER_COLOUR = 2;
    localparam logic [7:0]  HDR_FLAG         = 8'h00;
`endif
    localparam int unsigned        MSG_WORDS = 1 + WORDS_PER_COLOUR * NUM_COLOURS;
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMAGE_H - 1);
    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [AW:0]        U_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]        U_DEPTH   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]        U_MSG     = (AW + 1)'(MSG_WORDS);
    localparam logic [CW-1:0]      C_LAST    = CW'(NUM_COLOURS - 1);

    typedef enum logic [2:0] {StIdle, StHdr, StBoxX, StBoxY, StCount} state_e;

    // ---------------- MM decode and registers ----------------
    logic rd_en, wr_en, rd_q, rd_rise, flush, clr_drop;
    logic [7:0]  ctrl_q, interval_q, drop_q, drop_d, frame_cnt_q, frame_cnt_d;
    logic [15:0] roi_x0_q, roi_x1_q, roi_y0_q, roi_y1_q;

    assign rd_en    = s_chipselect & s_read;
    assign wr_en    = s_chipselect & s_write;
    assign rd_rise  = rd_en & ~rd_q;
    assign flush    = wr_en & (s_address == 3'd0) & s_writedata[4];
    assign clr_drop = wr_en & (s_address == 3'd0) & s_writedata[5];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 8'h01;
            roi_x0_q   <= 16'd0;
            roi_x1_q   <= 16'(IMAGE_W - 1);
            roi_y0_q   <= 16'd0;
            roi_y1_q   <= 16'(IMAGE_H - 1);
            interval_q <= 8'(MSG_INTERVAL);
            rd_q       <= 1'b0;
        end else begin
            rd_q <= rd_en;
            if (wr_en) begin
                case (s_address)
                    3'd0: ctrl_q <= s_writedata[7:0] & 8'hCF;  // flush/clear are strobes
                    3'd3: begin
                        roi_x0_q <= s_writedata[15:0];
                        roi_x1_q <= s_writedata[31:16];
                    end
                    3'd4: begin
                        roi_y0_q <= s_writedata[15:0];
                        roi_y1_q <= s_writedata[31:16];
                    end
                    3'd5: interval_q <= s_writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Pixel coordinates ----------------
    logic [COORD_W-1:0] x_q, y_q;
    logic               is_video_q, pix_beat, frame_end, hit_en, in_roi;
    logic [15:0]        x_ext, y_ext;

    assign pix_beat  = pix_valid & ~pix_sop;
    assign frame_end = pix_beat & pix_eop & is_video_q;
    assign x_ext     = 16'(x_q);
    assign y_ext     = 16'(y_q);
    assign in_roi    = (x_ext >= roi_x0_q) && (x_ext <= roi_x1_q) &&
                       (y_ext >= roi_y0_q) && (y_ext <= roi_y1_q);
    assign hit_en    = pix_beat & is_video_q & ctrl_q[0] & in_roi;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            is_video_q <= 1'b0;
        end else if (pix_valid && pix_sop) begin
            x_q        <= '0;
            y_q        <= '0;
            is_video_q <= pix_video;
        end else if (pix_valid) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + C_ONE;
            end else begin
                x_q <= x_q + C_ONE;
            end
        end
    end

    // ---------------- Per-colour trackers and snapshot ----------------
    logic [COORD_W-1:0] xmin_q [NUM_COLOURS], xmin_d [NUM_COLOURS], snap_xmin_q [NUM_COLOURS];
    logic [COORD_W-1:0] xmax_q [NUM_COLOURS], xmax_d [NUM_COLOURS], snap_xmax_q [NUM_COLOURS];
    logic [COORD_W-1:0] ymin_q [NUM_COLOURS], ymin_d [NUM_COLOURS], snap_ymin_q [NUM_COLOURS];
    logic [COORD_W-1:0] ymax_q [NUM_COLOURS], ymax_d [NUM_COLOURS], snap_ymax_q [NUM_COLOURS];
    logic [NUM_COLOURS-1:0] found_q, found_d, snap_found_q;
    logic snap_en;
    state_e state_q, state_d;

    assign snap_en = frame_end & (state_q == StIdle);

    always_comb begin
        found_d = found_q;
        for (int c = 0; c < NUM_COLOURS; c++) begin
            xmin_d[c] = xmin_q[c];
            xmax_d[c] = xmax_q[c];
            ymin_d[c] = ymin_q[c];
            ymax_d[c] = ymax_q[c];
            if (pix_valid && pix_sop) begin
                xmin_d[c]  = X_LAST;
                xmax_d[c]  = '0;
                ymin_d[c]  = Y_LAST;
                ymax_d[c]  = '0;
                found_d[c] = 1'b0;
            end else if (hit_en && pix_match[c]) begin
                if (x_q < xmin_q[c]) xmin_d[c] = x_q;
                if (x_q > xmax_q[c]) xmax_d[c] = x_q;
                if (y_q < ymin_q[c]) ymin_d[c] = y_q;
                ymax_d[c]  = y_q;  // lines arrive in order, so the latest hit is the max
                found_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            found_q      <= '0;
            snap_found_q <= '0;
            for (int c = 0; c < NUM_COLOURS; c++) begin
                xmin_q[c]      <= X_LAST;
                xmax_q[c]      <= '0;
                ymin_q[c]      <= Y_LAST;
                ymax_q[c]      <= '0;
                snap_xmin_q[c] <= X_LAST;
                snap_xmax_q[c] <= '0;
                snap_ymin_q[c] <= Y_LAST;
                snap_ymax_q[c] <= '0;
            end
        end else begin
            found_q <= found_d;
            for (int c = 0; c < NUM_COLOURS; c++) begin
                xmin_q[c] <= xmin_d[c];
                xmax_q[c] <= xmax_d[c];
                ymin_q[c] <= ymin_d[c];
                ymax_q[c] <= ymax_d[c];
            end
            // Snapshot takes next-state values so the eop pixel is included
            if (snap_en) begin
                snap_found_q <= found_d;
                for (int c = 0; c < NUM_COLOURS; c++) begin
                    snap_xmin_q[c] <= xmin_d[c];
                    snap_xmax_q[c] <= xmax_d[c];
                    snap_ymin_q[c] <= ymin_d[c];
                    snap_ymax_q[c] <= ymax_d[c];
                end
            end
        end
    end

`ifdef BBOX_COUNT_EN
    logic [31:0] cnt_q [NUM_COLOURS], cnt_d [NUM_COLOURS], snap_cnt_q [NUM_COLOURS];

    always_comb begin
        for (int c = 0; c < NUM_COLOURS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (pix_valid && pix_sop) begin
                cnt_d[c] = '0;
            end else if (hit_en && pix_match[c] && (cnt_q[c] != 32'hFFFF_FFFF)) begin
                cnt_d[c] = cnt_q[c] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_COLOURS; c++) begin
            if (reset) begin
                cnt_q[c]      <= '0;
                snap_cnt_q[c] <= '0;
            end else begin
                cnt_q[c] <= cnt_d[c];
                if (snap_en) snap_cnt_q[c] <= cnt_d[c];
            end
        end
    end
`endif

    // ---------------- Frame counter and drop accounting ----------------
    logic [AW:0] usedw_q, free_words;
    logic        space_ok, start, drop_inc;
    logic [7:0]  reload;

    assign free_words = U_DEPTH - usedw_q;
    assign space_ok   = free_words >= U_MSG;
    assign reload     = (interval_q == 8'd0) ? 8'd0 : interval_q - 8'd1;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_inc    = 1'b0;
        start       = 1'b0;
        if (frame_end) begin
            if (state_q != StIdle) begin
                drop_inc = 1'b1;
            end else if (frame_cnt_q == 8'd0) begin
                frame_cnt_d = reload;
                start       = space_ok;
                drop_inc    = ~space_ok;
            end else begin
                frame_cnt_d = frame_cnt_q - 8'd1;
            end
        end
        drop_d = drop_q;
        if (clr_drop) drop_d = 8'd0;
        else if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
            drop_q      <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
        end
    end

    // ---------------- Message FSM ----------------
    logic [CW-1:0] cidx_q, cidx_d;
    logic          fsm_push, full, empty, push, pop;
    logic [31:0]   fsm_word;

    always_comb begin
        state_d  = state_q;
        cidx_d   = cidx_q;
        fsm_push = 1'b0;
        fsm_word = '0;
        case (state_q)
            StIdle: begin
                cidx_d = '0;
                if (start) state_d = StHdr;
            end
            StHdr: begin
                fsm_push = 1'b1;
                fsm_word = {16'h4242, 8'(NUM_COLOURS) | HDR_FLAG, 8'(snap_found_q)};
                if (!full) state_d = StBoxX;
            end
            StBoxX: begin
                fsm_push = 1'b1;
                fsm_word = {16'(snap_xmin_q[cidx_q]), 16'(snap_xmax_q[cidx_q])};
                if (!full) state_d = StBoxY;
            end
            StBoxY: begin
                fsm_push = 1'b1;
                fsm_word = {16'(snap_ymin_q[cidx_q]), 16'(snap_ymax_q[cidx_q])};
                if (!full) begin
`ifdef BBOX_COUNT_EN
                    state_d = StCount;
`else
                    state_d = (cidx_q == C_LAST) ? StIdle : StBoxX;
                    cidx_d  = cidx_q + CW'(1);
`endif
                end
            end
`ifdef BBOX_COUNT_EN
            StCount: begin
                fsm_push = 1'b1;
                fsm_word = snap_cnt_q[cidx_q];
                if (!full) begin
                    state_d = (cidx_q == C_LAST) ? StIdle : StBoxX;
                    cidx_d  = cidx_q + CW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cidx_q  <= cidx_d;
        end
    end

    // ---------------- Show-ahead FIFO ----------------
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          msg_sel;

    assign msg_sel   = s_address == 3'd1;
    assign full      = usedw_q == U_DEPTH;
    assign empty     = usedw_q == '0;
    assign push      = fsm_push & ~full & ~flush;
    assign pop       = rd_rise & msg_sel & ~empty & ~flush;
    assign msg_avail = ~empty;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fsm_word;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      usedw_q <= usedw_q + U_ONE;
            else if (pop && !push) usedw_q <= usedw_q - U_ONE;
        end
    end

    // ---------------- Registered read data ----------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (s_address)
            3'd0: rd_mux = {drop_q, 16'(usedw_q), ctrl_q};
            3'd1: rd_mux = empty ? 32'd0 : mem_q[rd_ptr_q];
            3'd2: rd_mux = 32'h1234_EEE3;
            3'd3: rd_mux = {roi_x1_q, roi_x0_q};
            3'd4: rd_mux = {roi_y1_q, roi_y0_q};
            3'd5: rd_mux = {24'd0, interval_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_readdata <= '0;
        end else if (rd_en && (!msg_sel || rd_rise)) begin
            s_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_multi_colour_bbox.sv
// Self-checking bench for multi_colour_bbox on a reduced 32x16 image (default build).
module tb_multi_colour_bbox;
    localparam int W  = 32;
    localparam int H  = 16;
    localparam int NC = 4;

    // Unfound-colour words for a 32x16 image: x_min=31, y_min=15, max=0
    localparam logic [31:0] RX = 32'h001F_0000;
    localparam logic [31:0] RY = 32'h000F_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid, pix_sop, pix_eop, pix_video;
    logic [NC-1:0] pix_match;
    logic          s_chipselect, s_read, s_write;
    logic [2:0]    s_address;
    logic [31:0]   s_writedata, s_readdata;
    logic          msg_avail;

    always #5 clk = ~clk;

    multi_colour_bbox #(
        .NUM_COLOURS (NC),
        .COORD_W     (11),
        .IMAGE_W     (W),
        .IMAGE_H     (H),
        .FIFO_DEPTH  (64),
        .MSG_INTERVAL(6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_sop     (pix_sop),
        .pix_eop     (pix_eop),
        .pix_video   (pix_video),
        .pix_match   (pix_match),
        .s_chipselect(s_chipselect),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_address   (s_address),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .msg_avail   (msg_avail)
    );

    typedef struct packed {
        logic [31:0] roi_x;
        logic [31:0] roi_y;
        logic [31:0] hdr;
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] x3;
        logic [31:0] y3;
    } vec_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] exp;
    } reg_t;

    vec_t        vecs [5];
    reg_t        defs [6];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(negedge clk);
        d = s_readdata;
        s_chipselect = 1'b0; s_read = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        mm_read(a, d);
        check(name, d, exp);
    endtask

    // Colour 1 covers x 5..12, y 9..12; colour 3 hits only the last pixel (eop beat).
    // Junk beats with valid low are interleaved to prove they are ignored.
    task automatic drive_frame(input bit video);
        @(negedge clk);
        pix_valid = 1'b1; pix_sop = 1'b1; pix_video = video; pix_eop = 1'b0; pix_match = '1;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                int k;
                k = yy * W + xx;
                @(negedge clk);
                if (k % 61 == 60) begin
                    pix_valid = 1'b0; pix_sop = 1'b1; pix_eop = 1'b1; pix_match = '1;
                    @(negedge clk);
                end
                pix_valid    = 1'b1;
                pix_sop      = 1'b0;
                pix_video    = 1'b0;
                pix_eop      = (k == W * H - 1);
                pix_match    = '0;
                pix_match[1] = (xx >= 5) && (xx <= 12) && (yy >= 9) && (yy <= 12);
                pix_match[3] = (k == W * H - 1);
            end
        end
    endtask

    task automatic frame_done();
        @(negedge clk);
        pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_match = '0;
    endtask

    task automatic full_frame(input bit video);
        drive_frame(video);
        frame_done();
        repeat (20) @(negedge clk);
    endtask

    task automatic push_msg(input vec_t v);
        exp_q.push_back(v.hdr);
        exp_q.push_back(RX);   exp_q.push_back(RY);
        exp_q.push_back(v.x1); exp_q.push_back(v.y1);
        exp_q.push_back(RX);   exp_q.push_back(RY);
        exp_q.push_back(v.x3); exp_q.push_back(v.y3);
    endtask

    task automatic read_msgs(input int n, input string name);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            mm_read(3'd1, d);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: got %08h with no word expected", name, d);
            end else begin
                check(name, d, exp_q.pop_front());
            end
        end
    endtask

    task automatic check_defaults(input string tag);
        for (int i = 0; i < 6; i++) check({tag, "_reg"}, 32'(defs[i].addr), 32'(defs[i].addr));
    endtask

    task automatic check_default_regs(input string tag);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            mm_read(defs[i].addr, d);
            check($sformatf("%s_addr%0d", tag, defs[i].addr), d, defs[i].exp);
        end
    endtask

    initial begin
        logic [31:0] d;
        int exp_u [6];

        vecs[0] = '{32'h001F_0000, 32'h000F_0000, 32'h4242_040A,
                    32'h0005_000C, 32'h0009_000C, 32'h001F_001F, 32'h000F_000F};
        vecs[1] = '{32'h000A_0007, 32'h000F_0000, 32'h4242_0402,
                    32'h0007_000A, 32'h0009_000C, RX, RY};
        vecs[2] = '{32'h001F_0000, 32'h000B_000A, 32'h4242_0402,
                    32'h0005_000C, 32'h000A_000B, RX, RY};
        vecs[3] = '{32'h0003_0000, 32'h000F_0000, 32'h4242_0400, RX, RY, RX, RY};
        vecs[4] = '{32'h001F_000C, 32'h000F_000C, 32'h4242_040A,
                    32'h000C_000C, 32'h000C_000C, 32'h001F_001F, 32'h000F_000F};

        defs[0] = '{3'd0, 32'h0000_0001};
        defs[1] = '{3'd2, 32'h1234_EEE3};
        defs[2] = '{3'd3, 32'h001F_0000};
        defs[3] = '{3'd4, 32'h000F_0000};
        defs[4] = '{3'd5, 32'h0000_0006};
        defs[5] = '{3'd6, 32'h0000_0000};

        exp_u = '{9, 9, 9, 18, 18, 18};

        reset = 1'b1;
        pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_video = 1'b0; pix_match = '0;
        s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_readdata", s_readdata, 32'd0);
        check("rst_msg_avail", 32'(msg_avail), 32'd0);
        check_default_regs("rst");
        mm_write(3'd6, 32'hFFFF_FFFF);
        check_reg("addr6_write_ignored", 3'd6, 32'd0);
        check_reg("empty_msg_read", 3'd1, 32'd0);

        // ROI variants, one message per frame
        mm_write(3'd5, 32'd1);
        for (int i = 0; i < 5; i++) begin
            mm_write(3'd3, vecs[i].roi_x);
            mm_write(3'd4, vecs[i].roi_y);
            full_frame(1'b1);
            push_msg(vecs[i]);
            check($sformatf("vec%0d_msg_avail", i), 32'(msg_avail), 32'd1);
            check_reg($sformatf("vec%0d_status", i), 3'd0, 32'h0000_0901);
            read_msgs(9, $sformatf("vec%0d_msg", i));
        end
        check_reg("drained_msg_read", 3'd1, 32'd0);

        // INTERVAL=3: messages on frames 1 and 4 only
        mm_write(3'd3, 32'h001F_0000);
        mm_write(3'd4, 32'h000F_0000);
        mm_write(3'd5, 32'd3);
        for (int f = 0; f < 6; f++) begin
            full_frame(1'b1);
            check_reg($sformatf("interval_frame%0d_status", f + 1), 3'd0,
                      {8'd0, 16'(exp_u[f]), 8'h01});
        end
        mm_write(3'd0, 32'h0000_0011);
        check_reg("flush_status", 3'd0, 32'h0000_0001);
        check("flush_msg_avail", 32'(msg_avail), 32'd0);

        // Fill to 60 words, then a message frame finds too little space
        mm_write(3'd5, 32'd1);
        for (int f = 0; f < 7; f++) full_frame(1'b1);
        for (int i = 0; i < 3; i++) mm_read(3'd1, d);
        check_reg("fill_status", 3'd0, 32'h0000_3C01);
        full_frame(1'b1);
        check_reg("overflow_drop", 3'd0, 32'h0100_3C01);
        mm_write(3'd0, 32'h0000_0021);
        check_reg("drop_cleared", 3'd0, 32'h0000_3C01);
        mm_write(3'd0, 32'h0000_0011);
        check_reg("flush_full", 3'd0, 32'h0000_0001);

        // Flush on the cycle the FSM sits in BOX_X(2)
        drive_frame(1'b1);
        frame_done();
        repeat (4) @(negedge clk);
        mm_write(3'd0, 32'h0000_0011);
        check_reg("midmsg_flush_status", 3'd0, 32'h0000_0001);
        check("midmsg_flush_avail", 32'(msg_avail), 32'd0);
        full_frame(1'b1);
        push_msg(vecs[0]);
        read_msgs(9, "after_flush_msg");

        // Non-video packet: no message, no drop
        full_frame(1'b0);
        check_reg("nonvideo_status", 3'd0, 32'h0000_0001);
        check("nonvideo_avail", 32'(msg_avail), 32'd0);

        // Reset in the middle of a message
        mm_write(3'd3, 32'h000A_0007);
        mm_write(3'd4, 32'h000B_000A);
        mm_write(3'd5, 32'd2);
        mm_write(3'd0, 32'h0000_0003);
        drive_frame(1'b1);
        frame_done();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midmsg_rst_readdata", s_readdata, 32'd0);
        check("midmsg_rst_avail", 32'(msg_avail), 32'd0);
        repeat (20) @(negedge clk);
        check_default_regs("midmsg_rst");
        check("midmsg_rst_avail_late", 32'(msg_avail), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the run stalls
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
